// File: rtl/pipe_pkg.sv
// pipe_pkg: shared opcodes, hazard controller states and register constants
package pipe_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [4:0] REG_ZERO  = 5'd0;
    typedef enum logic [1:0] {RUN, BUSY, FLUSH} hz_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use compare between ID sources and the ID/EX load
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic [6:0] ex_opcode_i,
    input  logic       ex_reg_write_i,
    output logic       hazard_o
);
    assign hazard_o = ex_opcode_i == OP_LOAD && ex_reg_write_i && ex_rd_i != REG_ZERO &&
                      ((id_uses_rs1_i && id_rs1_i == ex_rd_i) || (id_uses_rs2_i && id_rs2_i == ex_rd_i));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/squash control for the 5-stage pipeline; HAZARD_PERF_EN builds perf counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       idex_write_reg_i,
    input  logic [6:0]       idex_opcode_i,
    input  logic             idex_reg_write_valid_i,
    input  logic             ex_busy_i,
    input  logic             ex_branch_taken_i,
    output logic             pc_write_en_o,
    output logic             pc_sel_target_o,
    output logic             ifid_flag_o,
    output logic             idex_flag_o,
    output logic             pc_replace_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);
    localparam logic [1:0] FRELOAD = 2'(FLUSH_CYCLES - 1);
    localparam hz_state_t  BR_NEXT = FLUSH_CYCLES == 1 ? RUN : FLUSH;

    hz_state_t  state_q, state_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic       load_use;

    load_use_detect u_lud (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .ex_rd_i       (idex_write_reg_i),
        .ex_opcode_i   (idex_opcode_i),
        .ex_reg_write_i(idex_reg_write_valid_i),
        .hazard_o      (load_use)
    );

    // Mealy outputs and next state; BUSY with ex_busy low behaves exactly like RUN
    always_comb begin
        pc_write_en_o   = 1'b1;
        pc_sel_target_o = 1'b0;
        ifid_flag_o     = 1'b1;
        idex_flag_o     = 1'b1;
        pc_replace_o    = 1'b0;
        state_d         = RUN;
        fcnt_d          = fcnt_q;
        if (!rst_n_i) begin
            pc_write_en_o = 1'b0;
            pc_replace_o  = 1'b1;
            fcnt_d        = '0;
        end else if (state_q == FLUSH) begin
            pc_replace_o = 1'b1;
            if (ex_branch_taken_i) begin
                pc_sel_target_o = 1'b1;
                fcnt_d          = FRELOAD;
                state_d         = BR_NEXT;
            end else begin
                state_d = fcnt_q > 2'd1 ? FLUSH : RUN;
                fcnt_d  = fcnt_q > 2'd1 ? fcnt_q - 2'd1 : 2'd0;
            end
        end else if (ex_busy_i) begin
            pc_write_en_o = 1'b0;
            ifid_flag_o   = 1'b0;
            idex_flag_o   = 1'b0;
            state_d       = BUSY;
        end else if (ex_branch_taken_i) begin
            pc_sel_target_o = 1'b1;
            pc_replace_o    = 1'b1;
            fcnt_d          = FRELOAD;
            state_d         = BR_NEXT;
        end else if (load_use) begin
            pc_write_en_o = 1'b0;
            ifid_flag_o   = 1'b0;
            pc_replace_o  = 1'b1;
        end
    end

    // state and flush drain counter
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic             accept_br;
    logic [CNT_W-1:0] stall_q, flush_q;

    assign accept_br      = rst_n_i && ex_branch_taken_i && (state_q == FLUSH || !ex_busy_i);
    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

    // perf counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write_en_o) stall_q <= stall_q + CNT_W'(1);
            if (accept_br) flush_q <= flush_q + CNT_W'(1);
        end
    end
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, bubble, flush, busy and reset behaviour
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [4:0] NORM  = 5'b10110;
    localparam logic [4:0] RST   = 5'b00111;
    localparam logic [4:0] BUB   = 5'b00011;
    localparam logic [4:0] STALL = 5'b00000;
    localparam logic [4:0] BR    = 5'b11111;
    localparam logic [4:0] FL    = 5'b10111;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, idex_wr = '0;
    logic        u1 = 1'b0, u2 = 1'b0, wv = 1'b0, busy = 1'b0, br = 1'b0;
    logic [6:0]  opc = 7'b0110011;
    logic        pc_we, pc_sel, ifid, idex, rep;
    logic [31:0] stall_cnt, flush_cnt;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
        .idex_write_reg_i(idex_wr), .idex_opcode_i(opc), .idex_reg_write_valid_i(wv),
        .ex_busy_i(busy), .ex_branch_taken_i(br),
        .pc_write_en_o(pc_we), .pc_sel_target_o(pc_sel), .ifid_flag_o(ifid),
        .idex_flag_o(idex), .pc_replace_o(rep),
        .stall_cycles_o(stall_cnt), .flush_count_o(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one cycle: drive mid-period, check Mealy outputs 1ns later
    task automatic cyc(input string tag, input logic r, input logic b, input logic t,
                       input logic lu, input logic [4:0] exp);
        @(negedge clk);
        rst_n = r; busy = b; br = t;
        opc = lu ? OP_LOAD : 7'b0110011; wv = 1'b1; idex_wr = 5'd5;
        id_rs1 = 5'd5; id_rs2 = 5'd7; u1 = 1'b1; u2 = 1'b1;
        #1 chk(tag, {27'd0, pc_we, pc_sel, ifid, idex, rep}, {27'd0, exp});
    endtask

    task automatic cyc_raw(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                           input logic a1, input logic a2, input logic [4:0] rd,
                           input logic [4:0] exp);
        @(negedge clk);
        rst_n = 1'b1; busy = 1'b0; br = 1'b0; opc = OP_LOAD; wv = 1'b1;
        id_rs1 = r1; id_rs2 = r2; u1 = a1; u2 = a2; idex_wr = rd;
        #1 chk(tag, {27'd0, pc_we, pc_sel, ifid, idex, rep}, {27'd0, exp});
    endtask

    task automatic cnt(input string tag, input int s, input int f);
        chk({tag, "_stall"}, stall_cnt, PERF ? 32'(s) : 32'd0);
        chk({tag, "_flush"}, flush_cnt, PERF ? 32'(f) : 32'd0);
    endtask

    initial begin
        cyc("rst0", 0, 0, 0, 0, RST);
        cyc("rst1", 0, 1, 1, 1, RST);
        cyc("run0", 1, 0, 0, 0, NORM);
        cnt("run0", 0, 0);
        cyc("lu_bub", 1, 0, 0, 1, BUB);
        cyc("lu_done", 1, 0, 0, 0, NORM);
        cnt("lu", 1, 0);
        cyc_raw("x0", 5'd0, 5'd0, 1, 1, 5'd0, NORM);
        cyc_raw("no_use", 5'd5, 5'd0, 0, 0, 5'd5, NORM);
        cyc_raw("rs2_lu", 5'd1, 5'd9, 1, 1, 5'd9, BUB);
        cyc("after_rs2", 1, 0, 0, 0, NORM);
        cnt("rs2", 2, 0);
        cyc("br", 1, 0, 1, 0, BR);
        cyc("br_fl", 1, 0, 0, 0, FL);
        cyc("br_done", 1, 0, 0, 0, NORM);
        cnt("br", 2, 1);
        cyc("rst2", 0, 0, 0, 0, RST);
        for (int i = 0; i < 4; i++) cyc("busy_lu", 1, 1, 0, 1, STALL);
        cyc("busy_end_bub", 1, 0, 0, 1, BUB);
        cyc("busy_done", 1, 0, 0, 0, NORM);
        cnt("busy", 5, 0);
        cyc("busy_br0", 1, 1, 1, 0, STALL);
        cyc("busy_br1", 1, 1, 1, 0, STALL);
        cyc("busy_br_acc", 1, 0, 1, 0, BR);
        cyc("busy_br_fl", 1, 0, 0, 0, FL);
        cyc("busy_br_done", 1, 0, 0, 0, NORM);
        cnt("busy_br", 7, 1);
        cyc("br2", 1, 0, 1, 0, BR);
        cyc("fl_ign", 1, 1, 0, 1, FL);
        cyc("fl_ign_done", 1, 0, 0, 0, NORM);
        cnt("fl_ign", 7, 2);
        cyc("br3", 1, 0, 1, 0, BR);
        cyc("fl_reload", 1, 0, 1, 0, BR);
        cyc("fl_after", 1, 0, 0, 0, FL);
        cyc("reload_done", 1, 0, 0, 0, NORM);
        cnt("reload", 7, 4);
        cyc("br4", 1, 0, 1, 0, BR);
        cyc("rst_fl", 0, 0, 0, 0, RST);
        cyc("rel_run", 1, 0, 0, 0, NORM);
        cnt("rel", 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
